// File: rtl/vector_mem_unit.sv
`default_nettype none
// ============================================================================
// Module   : vector_mem_unit
// Purpose  : Vector load/store engine; moves VEC_W-bit register-file vectors
//            to/from word-addressed memory as NBEATS req/ack beats.
// Revision : 1.0 - initial release
// ============================================================================
module vector_mem_unit #(
    parameter int VEC_W  = 512,
    parameter int BEAT_W = 32,
    parameter int NBEATS = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_is_store,
    input  logic [1:0]        cmd_reg,
    input  logic [ADDR_W-1:0] cmd_mem_addr,
    output logic              load,
    output logic [1:0]        load_addr_reg,
    output logic [VEC_W-1:0]  load_data,
    output logic              store,
    output logic [1:0]        store_addr_reg,
    input  logic [VEC_W-1:0]  store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              busy
);

    localparam int                 c_cnt_w     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(NBEATS - 1);

    localparam logic [2:0] c_idle       = 3'd0;
    localparam logic [2:0] c_rd_beat    = 3'd1;
    localparam logic [2:0] c_ld_write   = 3'd2;
    localparam logic [2:0] c_st_fetch   = 3'd3;
    localparam logic [2:0] c_st_capture = 3'd4;
    localparam logic [2:0] c_wr_beat    = 3'd5;
    localparam logic [2:0] c_done       = 3'd6;

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_beat;
    logic [1:0]         r_reg;
    logic [VEC_W-1:0]   r_buf;

    logic               w_beat_done;
    logic [c_cnt_w-1:0] w_next_beat;
    logic [BEAT_W-1:0]  w_next_wdata;

    // An ack only counts against an outstanding request.
    assign w_beat_done  = mem_req & mem_ack;
    assign w_next_beat  = r_beat + 1'b1;
    assign w_next_wdata = r_buf[int'(w_next_beat) * BEAT_W +: BEAT_W];

    assign cmd_ready = (r_state == c_idle);
    assign busy      = (r_state != c_idle);
    assign load      = (r_state == c_ld_write);
    assign store     = (r_state == c_st_fetch);
    assign done      = (r_state == c_done);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= c_idle;
            r_beat         <= '0;
            r_reg          <= '0;
            r_buf          <= '0;
            load_addr_reg  <= '0;
            load_data      <= '0;
            store_addr_reg <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (cmd_valid) begin
                        r_reg    <= cmd_reg;
                        r_beat   <= '0;
                        mem_addr <= cmd_mem_addr;
                        if (cmd_is_store) begin
                            store_addr_reg <= cmd_reg;
                            r_state        <= c_st_fetch;
                        end else begin
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                            r_state <= c_rd_beat;
                        end
                    end
                end

                c_rd_beat: begin
                    if (w_beat_done) begin
                        r_buf[int'(r_beat) * BEAT_W +: BEAT_W] <= mem_rdata;
                        if (r_beat == c_last_beat) begin
                            // Final beat bypasses the buffer so load_data is ready next cycle.
                            mem_req       <= 1'b0;
                            load_data     <= {mem_rdata, r_buf[VEC_W-BEAT_W-1:0]};
                            load_addr_reg <= r_reg;
                            r_state       <= c_ld_write;
                        end else begin
                            r_beat   <= w_next_beat;
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end
                end

                c_ld_write: r_state <= c_done;

                c_st_fetch: r_state <= c_st_capture;

                c_st_capture: begin
                    // Beat 0 comes straight from the register file since the buffer loads on this edge.
                    r_buf     <= store_data;
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_wdata <= store_data[BEAT_W-1:0];
                    r_beat    <= '0;
                    r_state   <= c_wr_beat;
                end

                c_wr_beat: begin
                    if (w_beat_done) begin
                        if (r_beat == c_last_beat) begin
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            r_state <= c_done;
                        end else begin
                            r_beat    <= w_next_beat;
                            mem_addr  <= mem_addr + 1'b1;
                            mem_wdata <= w_next_wdata;
                        end
                    end
                end

                c_done: r_state <= c_idle;

                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vector_mem_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_mem_unit
// Purpose  : Self-checking bench for vector_mem_unit with a randomized
//            memory responder and register-file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_mem_unit;

    logic         clk;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_is_store;
    logic [1:0]   cmd_reg;
    logic [15:0]  cmd_mem_addr;
    logic         load;
    logic [1:0]   load_addr_reg;
    logic [511:0] load_data;
    logic         store;
    logic [1:0]   store_addr_reg;
    logic [511:0] store_data;
    logic         mem_req;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_ack;
    logic         done;
    logic         busy;

    vector_mem_unit #(
        .VEC_W (512),
        .BEAT_W(32),
        .NBEATS(16),
        .ADDR_W(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_is_store  (cmd_is_store),
        .cmd_reg       (cmd_reg),
        .cmd_mem_addr  (cmd_mem_addr),
        .load          (load),
        .load_addr_reg (load_addr_reg),
        .load_data     (load_data),
        .store         (store),
        .store_addr_reg(store_addr_reg),
        .store_data    (store_data),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .done          (done),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0]  mem [0:65535];
    logic [511:0] regfile [0:3];

    // Completed beats, in order
    logic [15:0] bq_addr [$];
    logic [31:0] bq_data [$];
    logic        bq_we   [$];

    int max_wait    = 0;
    int total_waits = 0;
    int stab_viol   = 0;
    int n_load      = 0;
    int n_store     = 0;
    int n_done      = 0;
    int overlap     = 0;

    function automatic logic [511:0] rand_vec();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Memory responder: random ack latency, spurious acks while idle, stability watch.
    initial begin : responder
        int          wait_left;
        logic        have_prev, p_ack, p_we, s_req, s_we;
        logic [15:0] p_addr, s_addr;
        logic [31:0] p_wdata, s_wdata;
        mem_ack = 1'b0; mem_rdata = '0; wait_left = 0;
        have_prev = 1'b0; p_ack = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
        forever begin
            @(negedge clk);
            s_req = mem_req; s_addr = mem_addr; s_wdata = mem_wdata; s_we = mem_we;
            if (mem_req) begin
                if (have_prev && !p_ack &&
                    (mem_addr !== p_addr || mem_wdata !== p_wdata || mem_we !== p_we))
                    stab_viol++;
                if (wait_left == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                    wait_left--;
                    total_waits++;
                end
                have_prev = 1'b1; p_ack = mem_ack;
                p_addr = mem_addr; p_wdata = mem_wdata; p_we = mem_we;
            end else begin
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
                have_prev = 1'b0;
                wait_left = (max_wait > 0) ? int'($urandom_range(0, max_wait)) : 0;
            end
            @(posedge clk);
            if (s_req && mem_ack && !reset) begin
                bq_addr.push_back(s_addr);
                bq_we.push_back(s_we);
                bq_data.push_back(s_we ? s_wdata : mem_rdata);
                if (s_we) mem[s_addr] = s_wdata;
                wait_left = (max_wait > 0) ? int'($urandom_range(0, max_wait)) : 0;
            end
        end
    end

    // Register-file read port: data valid only in the cycle after the store strobe.
    initial begin : regfile_port
        logic       p_store;
        logic [1:0] p_sreg;
        store_data = '0; p_store = 1'b0; p_sreg = '0;
        forever begin
            @(negedge clk);
            store_data = p_store ? regfile[p_sreg] : rand_vec();
            p_store = store;
            p_sreg  = store_addr_reg;
            if (load)  n_load++;
            if (store) n_store++;
            if (done)  n_done++;
            if (done && (load || store)) overlap++;
        end
    end

    task automatic run_cmd(input logic st, input logic [1:0] r, input logic [15:0] a,
                           output int c_load, output int c_store, output int c_done,
                           output int c_ready, output int waits,
                           output logic [511:0] ld_vec, output logic [1:0] ld_reg);
        int cyc;
        int w0;
        c_load = -1; c_store = -1; c_done = -1; c_ready = -1;
        ld_vec = '0; ld_reg = '0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_is_store = st; cmd_reg = r; cmd_mem_addr = a;
        @(posedge clk);
        bq_addr.delete(); bq_data.delete(); bq_we.delete();
        w0 = total_waits;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1;
        while (cyc < 300) begin
            if (load && c_load < 0) begin
                c_load = cyc; ld_vec = load_data; ld_reg = load_addr_reg;
            end
            if (store && c_store < 0) c_store = cyc;
            if (done && c_done < 0)   c_done = cyc;
            if (cmd_ready) begin
                c_ready = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        waits = total_waits - w0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({cmd_ready, busy} !== 2'b10) begin errors++;
            $display("FAIL reset_ready_busy: got %b expected 10", {cmd_ready, busy}); end
        checks++; if ({load, store, mem_req, mem_we, done} !== 5'b0) begin errors++;
            $display("FAIL reset_strobes: got %b expected 00000", {load, store, mem_req, mem_we, done}); end
        checks++; if (mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin errors++;
            $display("FAIL reset_mem_bus: got addr %h wdata %h expected 0", mem_addr, mem_wdata); end
        checks++; if (load_data !== '0 || load_addr_reg !== 2'd0 || store_addr_reg !== 2'd0) begin errors++;
            $display("FAIL reset_regs: got ld_reg %0d st_reg %0d data_nonzero %b expected 0",
                     load_addr_reg, store_addr_reg, |load_data); end
        reset = 1'b0;
    endtask

    task automatic test_load_zero_wait();
        logic [511:0] exp, got;
        logic [1:0]   greg;
        int cl, cs, cd, cr, w, bad;
        max_wait = 0;
        for (int i = 0; i < 16; i++) begin
            mem[16'h0100 + i] = 32'hA500_0000 + i;
            exp[32*i +: 32]   = 32'hA500_0000 + i;
        end
        run_cmd(1'b0, 2'd2, 16'h0100, cl, cs, cd, cr, w, got, greg);
        checks++; if (cl !== 17) begin errors++; $display("FAIL load_cycle: got %0d expected 17", cl); end
        checks++; if (cd !== 18) begin errors++; $display("FAIL load_done_cycle: got %0d expected 18", cd); end
        checks++; if (cr !== 19) begin errors++; $display("FAIL load_ready_cycle: got %0d expected 19", cr); end
        checks++; if (cs !== -1) begin errors++; $display("FAIL load_no_store: got %0d expected -1", cs); end
        checks++; if (greg !== 2'd2) begin errors++; $display("FAIL load_reg: got %0d expected 2", greg); end
        checks++; if (got !== exp) begin errors++; $display("FAIL load_data: got %h expected %h", got[127:0], exp[127:0]); end
        bad = 0;
        for (int i = 0; i < 16 && i < bq_addr.size(); i++)
            if (bq_addr[i] !== 16'(16'h0100 + i) || bq_we[i] !== 1'b0) bad++;
        checks++; if (bq_addr.size() !== 16 || bad !== 0) begin errors++;
            $display("FAIL load_beats: got %0d beats %0d bad expected 16 beats 0 bad", bq_addr.size(), bad); end
    endtask

    task automatic test_store_zero_wait();
        logic [511:0] v, got;
        logic [1:0]   greg;
        int cl, cs, cd, cr, w, bad;
        max_wait = 0;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = (i == 3) ? 32'h1234_5678 : 32'hDEAD_BEEF;
        regfile[1] = v;
        run_cmd(1'b1, 2'd1, 16'h0200, cl, cs, cd, cr, w, got, greg);
        checks++; if (cs !== 1)  begin errors++; $display("FAIL store_cycle: got %0d expected 1", cs); end
        checks++; if (cd !== 19) begin errors++; $display("FAIL store_done_cycle: got %0d expected 19", cd); end
        checks++; if (cr !== 20) begin errors++; $display("FAIL store_ready_cycle: got %0d expected 20", cr); end
        checks++; if (cl !== -1) begin errors++; $display("FAIL store_no_load: got %0d expected -1", cl); end
        checks++; if (store_addr_reg !== 2'd1) begin errors++;
            $display("FAIL store_reg: got %0d expected 1", store_addr_reg); end
        bad = 0;
        for (int i = 0; i < 16 && i < bq_addr.size(); i++)
            if (bq_addr[i] !== 16'(16'h0200 + i) || bq_we[i] !== 1'b1 || bq_data[i] !== v[32*i +: 32]) bad++;
        checks++; if (bq_addr.size() !== 16 || bad !== 0) begin errors++;
            $display("FAIL store_beats: got %0d beats %0d bad expected 16 beats 0 bad", bq_addr.size(), bad); end
        checks++; if (mem[16'h0203] !== 32'h1234_5678) begin errors++;
            $display("FAIL store_beat3: got %h expected 12345678", mem[16'h0203]); end
    endtask

    task automatic test_wait_states();
        logic [511:0] exp, got;
        logic [1:0]   greg, r;
        logic [15:0]  a;
        logic         st;
        int cl, cs, cd, cr, w, bad, all_waits;
        max_wait = 3;
        all_waits = 0;
        for (int k = 0; k < 8; k++) begin
            st = 1'($urandom_range(0, 1));
            r  = 2'($urandom_range(0, 3));
            a  = 16'($urandom);
            if (st) regfile[r] = rand_vec();
            for (int i = 0; i < 16; i++) exp[32*i +: 32] = st ? regfile[r][32*i +: 32] : mem[16'(a + i)];
            run_cmd(st, r, a, cl, cs, cd, cr, w, got, greg);
            all_waits += w;
            checks++; if (cd !== (st ? 19 : 18) + w || cr !== cd + 1) begin errors++;
                $display("FAIL wait_timing[%0d]: got done %0d ready %0d expected done %0d ready %0d",
                         k, cd, cr, (st ? 19 : 18) + w, (st ? 20 : 19) + w); end
            bad = 0;
            for (int i = 0; i < 16; i++) if (mem[16'(a + i)] !== exp[32*i +: 32]) bad++;
            if (!st && (got !== exp || greg !== r)) bad++;
            checks++; if (bad !== 0) begin errors++;
                $display("FAIL wait_data[%0d]: got %0d bad words expected 0", k, bad); end
        end
        checks++; if (stab_viol !== 0) begin errors++;
            $display("FAIL wait_stability: got %0d changes while unacked expected 0", stab_viol); end
        checks++; if (all_waits <= 0) begin errors++;
            $display("FAIL wait_inserted: got %0d wait cycles expected >0", all_waits); end
    endtask

    task automatic test_addr_wrap();
        logic [511:0] exp, got;
        logic [1:0]   greg;
        int cl, cs, cd, cr, w, bad;
        max_wait = 1;
        for (int i = 0; i < 16; i++) begin
            mem[16'(16'hFFF8 + i)] = $urandom;
            exp[32*i +: 32] = mem[16'(16'hFFF8 + i)];
        end
        run_cmd(1'b0, 2'd3, 16'hFFF8, cl, cs, cd, cr, w, got, greg);
        bad = 0;
        for (int i = 0; i < 16 && i < bq_addr.size(); i++)
            if (bq_addr[i] !== 16'(16'hFFF8 + i)) bad++;
        checks++; if (bq_addr.size() !== 16 || bad !== 0) begin errors++;
            $display("FAIL wrap_addrs: got %0d beats %0d bad expected 16 beats 0 bad", bq_addr.size(), bad); end
        checks++; if (got !== exp) begin errors++;
            $display("FAIL wrap_data: got %h expected %h", got[511:384], exp[511:384]); end
        checks++; if (cd !== 18 + w) begin errors++; $display("FAIL wrap_done: got %0d expected %0d", cd, 18 + w); end
    endtask

    task automatic test_busy_reject();
        logic [511:0] v, ld_exp, ld_got;
        int acc_cyc, st_cyc, n_st, n_ld, n_dn, nr, nw, bad;
        max_wait = 0;
        v = rand_vec();
        regfile[3] = v;
        for (int i = 0; i < 16; i++) ld_exp[32*i +: 32] = mem[16'h0300 + i];
        acc_cyc = -1; st_cyc = -1; n_st = 0; n_ld = 0; n_dn = 0; ld_got = '0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_is_store = 1'b0; cmd_reg = 2'd0; cmd_mem_addr = 16'h0300;
        @(posedge clk);
        bq_addr.delete(); bq_data.delete(); bq_we.delete();
        @(negedge clk);
        cmd_is_store = 1'b1; cmd_reg = 2'd3; cmd_mem_addr = 16'h0400;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (store) begin n_st++; if (st_cyc < 0) st_cyc = cyc; end
            if (load)  begin n_ld++; ld_got = load_data; end
            if (done)  n_dn++;
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            else if (acc_cyc > 0) cmd_valid = 1'b0;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        nr = 0; nw = 0; bad = 0;
        for (int i = 0; i < bq_addr.size(); i++) begin
            if (bq_we[i]) begin
                if (bq_addr[i] !== 16'(16'h0400 + nw) || bq_data[i] !== v[32*(nw % 16) +: 32]) bad++;
                nw++;
            end else begin
                if (bq_addr[i] !== 16'(16'h0300 + nr)) bad++;
                nr++;
            end
        end
        checks++; if (acc_cyc !== 19) begin errors++; $display("FAIL busy_accept_cycle: got %0d expected 19", acc_cyc); end
        checks++; if (st_cyc !== 20 || n_st !== 1) begin errors++;
            $display("FAIL busy_store_once: got cycle %0d count %0d expected cycle 20 count 1", st_cyc, n_st); end
        checks++; if (n_ld !== 1 || n_dn !== 2) begin errors++;
            $display("FAIL busy_pulses: got load %0d done %0d expected load 1 done 2", n_ld, n_dn); end
        checks++; if (ld_got !== ld_exp) begin errors++;
            $display("FAIL busy_load_data: got %h expected %h", ld_got[127:0], ld_exp[127:0]); end
        checks++; if (nr !== 16 || nw !== 16 || bad !== 0) begin errors++;
            $display("FAIL busy_beats: got reads %0d writes %0d bad %0d expected 16 16 0", nr, nw, bad); end
        checks++; if (overlap !== 0) begin errors++;
            $display("FAIL no_overlap: got %0d cycles with done and strobe expected 0", overlap); end
    endtask

    task automatic test_reset_mid_store();
        logic [511:0] v, exp, got;
        logic [31:0]  untouched;
        logic [1:0]   greg;
        int cyc, d0, bad, cl, cs, cd, cr, w;
        max_wait = 0;
        v = rand_vec();
        regfile[0] = v;
        untouched = mem[16'h0504];
        @(negedge clk);
        cmd_valid = 1'b1; cmd_is_store = 1'b1; cmd_reg = 2'd0; cmd_mem_addr = 16'h0500;
        @(posedge clk);
        bq_addr.delete(); bq_data.delete(); bq_we.delete();
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1;
        while (bq_addr.size() < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (mem_req !== 1'b1 || cyc !== 7) begin errors++;
            $display("FAIL rst_mid_inflight: got req %b cycle %0d expected req 1 cycle 7", mem_req, cyc); end
        d0 = n_done;
        #1 reset = 1'b1;
        #1;
        checks++; if ({cmd_ready, busy, load, store, mem_req, mem_we, done} !== 7'b1000000) begin errors++;
            $display("FAIL rst_mid_ctrl: got %b expected 1000000",
                     {cmd_ready, busy, load, store, mem_req, mem_we, done}); end
        checks++; if (mem_addr !== 16'h0 || mem_wdata !== 32'h0 || store_addr_reg !== 2'd0 || load_data !== '0) begin errors++;
            $display("FAIL rst_mid_data: got addr %h wdata %h st_reg %0d expected 0", mem_addr, mem_wdata, store_addr_reg); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 4; i++) if (mem[16'h0500 + i] !== v[32*i +: 32]) bad++;
        checks++; if (n_done !== d0 || bq_addr.size() !== 4 || bad !== 0 || mem[16'h0504] !== untouched) begin errors++;
            $display("FAIL rst_mid_abort: got done %0d beats %0d bad %0d expected done %0d beats 4 bad 0",
                     n_done - d0, bq_addr.size(), bad, 0); end
        for (int i = 0; i < 16; i++) exp[32*i +: 32] = mem[16'h0500 + i];
        run_cmd(1'b0, 2'd1, 16'h0500, cl, cs, cd, cr, w, got, greg);
        checks++; if (cd !== 18 || got !== exp || greg !== 2'd1) begin errors++;
            $display("FAIL rst_then_load: got done %0d reg %0d data_ok %b expected done 18 reg 1 data_ok 1",
                     cd, greg, got === exp); end
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_is_store = 1'b0; cmd_reg = '0; cmd_mem_addr = '0;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) regfile[i] = rand_vec();
        test_reset();
        test_load_zero_wait();
        test_store_zero_wait();
        test_wait_states();
        test_addr_wrap();
        test_busy_reject();
        test_reset_mid_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
